// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: FSM state encoding,
// default geometry and the qualifying-step count for one full run.
package matmul_pkg;

  localparam int N_DEFAULT     = 4;
  localparam int IDX_W_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // One CLEAR, N MACs and one WRITE per output element.
  function automatic int steps_per_run(input int n);
    return n * n * (n + 2);
  endfunction

  localparam int STEPS_PER_RUN = N_DEFAULT * N_DEFAULT * (N_DEFAULT + 2);

endpackage

// File: rtl/matmul_idx_counter.sv
// Index counter that counts 0..N-1; wrap_o flags the last value so the next
// counter up the chain can advance. clr_i has priority over inc_i.
module matmul_idx_counter
  import matmul_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  assign wrap_o = (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Index sequencer for C = A*B: walks i, j, k on step_en and issues accumulator
// clear, MAC-enable and write-back strobes. abort returns to IDLE from any state.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] a_row,
  output logic [IDX_W-1:0] a_col,
  output logic [IDX_W-1:0] b_row,
  output logic [IDX_W-1:0] b_col,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_row,
  output logic [IDX_W-1:0] wr_col
);

  state_e state_q;
  state_e state_d;

  logic [IDX_W-1:0] i_cnt, j_cnt, k_cnt;
  logic             i_wrap, j_wrap, k_wrap;
  logic             step_ok;
  logic             last_cell;
  logic             idx_clr;
  logic             k_clr, k_inc;
  logic             j_inc, i_inc;

  assign step_ok   = step_en & ~abort;
  assign last_cell = i_wrap & j_wrap;

  // All indices return to zero on abort, on leaving DONE and on launch.
  assign idx_clr = abort | (state_q == DONE) | ((state_q == IDLE) & start);

  // k holds at N-1 through WRITE and is rezeroed on the way out of CLEAR.
  assign k_clr = idx_clr | ((state_q == CLEAR) & step_ok);
  assign k_inc = (state_q == MAC) & step_ok & ~k_wrap;
  assign j_inc = (state_q == WRITE) & step_ok & ~last_cell;
  assign i_inc = j_inc & j_wrap;

  matmul_idx_counter #(.N(N), .IDX_W(IDX_W)) u_k_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (k_clr),
    .inc_i  (k_inc),
    .cnt_o  (k_cnt),
    .wrap_o (k_wrap)
  );

  matmul_idx_counter #(.N(N), .IDX_W(IDX_W)) u_j_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (idx_clr),
    .inc_i  (j_inc),
    .cnt_o  (j_cnt),
    .wrap_o (j_wrap)
  );

  matmul_idx_counter #(.N(N), .IDX_W(IDX_W)) u_i_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (idx_clr),
    .inc_i  (i_inc),
    .cnt_o  (i_cnt),
    .wrap_o (i_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)   state_d = CLEAR;
      CLEAR:   if (step_ok) state_d = MAC;
      MAC:     if (step_ok && k_wrap) state_d = WRITE;
      WRITE:   if (step_ok) state_d = last_cell ? DONE : CLEAR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign acc_clr = (state_q == CLEAR) & step_ok;
  assign acc_en  = (state_q == MAC) & step_ok;
  assign wr_en   = (state_q == WRITE) & step_ok;

  assign a_row  = i_cnt;
  assign wr_row = i_cnt;
  assign a_col  = k_cnt;
  assign b_row  = k_cnt;
  assign b_col  = j_cnt;
  assign wr_col = j_cnt;

endmodule
